// File: rtl/program_counter_if.sv
// Fetch-side bus between the program counter and its controller.
// The controller (master) supplies redirect and halt requests; the
// program counter (slave) returns the registered fetch address and enable.
interface program_counter_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] new_pc;
   logic              change_pc;
   logic              halt;
   logic [ADDR_W-1:0] instr_addr;
   logic              instr_fetch_en;

   modport master (
      output new_pc,
      output change_pc,
      output halt,
      input  instr_addr,
      input  instr_fetch_en
   );

   modport slave (
      input  new_pc,
      input  change_pc,
      input  halt,
      output instr_addr,
      output instr_fetch_en
   );
endinterface

// File: rtl/program_counter.sv
// Program counter and instruction-fetch request generator for the vcpu1
// fetch stage. Steps by INCR bytes per fetched address, redirects to
// new_pc on change_pc, and freezes on the next unfetched address while
// halt is high. Both outputs are plain registers.
module program_counter #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int                INCR       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   program_counter_if.slave   pc_bus
);

   localparam logic [ADDR_W-1:0] INCR_V = ADDR_W'(INCR);

   logic [ADDR_W-1:0] addr_q;
   logic              fetch_en_q;
   logic [ADDR_W-1:0] next_seq;

   // Next sequential address: only advance past an address once it has
   // actually been presented with fetch enable high, so nothing is skipped.
   always_comb begin
      next_seq = addr_q;
      if (fetch_en_q) begin
         next_seq = addr_q + INCR_V;
      end
   end

   // Address/enable register: redirect beats halt beats sequential fetch.
   // A redirect taken while halted lands the target but waits for halt to drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= RESET_ADDR;
         fetch_en_q <= 1'b0;
      end else if (pc_bus.change_pc) begin
         addr_q     <= pc_bus.new_pc;
         fetch_en_q <= ~pc_bus.halt;
      end else if (pc_bus.halt) begin
         addr_q     <= next_seq;
         fetch_en_q <= 1'b0;
      end else begin
         addr_q     <= next_seq;
         fetch_en_q <= 1'b1;
      end
   end

   assign pc_bus.instr_addr     = addr_q;
   assign pc_bus.instr_fetch_en = fetch_en_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed scenarios with literal expectations,
// then randomized redirect/halt/reset traffic checked every cycle against
// a behavioural model of the fetch stream.
module tb_program_counter;

   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   program_counter_if #(.ADDR_W(ADDR_W)) bus ();

   program_counter #(
      .ADDR_W     (ADDR_W),
      .RESET_ADDR (32'h0000_0000),
      .INCR       (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pc_bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: m_addr is the address on the bus; it moves on only once it has
   // been fetched. Fetch enable is simply "not halted" at the last edge.
   logic [ADDR_W-1:0] m_addr = 32'h0;
   logic              m_en   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_addr = 32'h0;
         m_en   = 1'b0;
      end else begin
         logic [ADDR_W-1:0] unfetched;
         unfetched = m_en ? (m_addr + 32'd4) : m_addr;
         m_addr = bus.change_pc ? bus.new_pc : unfetched;
         m_en   = !bus.halt;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      n_cmp++;
      if (bus.instr_addr !== m_addr || bus.instr_fetch_en !== m_en) begin
         n_bad++;
         $display("FAIL model t=%0t: got addr=%h en=%b, want addr=%h en=%b",
                  $time, bus.instr_addr, bus.instr_fetch_en, m_addr, m_en);
      end
   end

   task automatic check_lit(input string name, input logic [ADDR_W-1:0] a,
                            input logic e);
      n_cmp++;
      if (bus.instr_addr !== a || bus.instr_fetch_en !== e) begin
         n_bad++;
         $display("FAIL %s t=%0t: got addr=%h en=%b, want addr=%h en=%b",
                  name, $time, bus.instr_addr, bus.instr_fetch_en, a, e);
      end
   endtask

   task automatic drive(input logic cp, input logic [ADDR_W-1:0] np,
                        input logic h);
      bus.change_pc = cp;
      bus.new_pc    = np;
      bus.halt      = h;
   endtask

   // Advance to the next falling edge (mid-cycle, outputs settled).
   task automatic cyc();
      @(negedge clk);
   endtask

   // Pulse reset low strictly between edges, checking the outputs clear
   // without any clock edge.
   task automatic async_reset(input string name);
      #2 rst_n = 1'b0;
      #1 check_lit(name, 32'h0, 1'b0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      drive(1'b0, 32'h0, 1'b0);

      // Reset held, then released between edges.
      cyc(); cyc();
      check_lit("rst_hold", 32'h0, 1'b0);
      #2 rst_n = 1'b1;
      cyc(); check_lit("first_fetch", 32'h0, 1'b1);
      cyc(); check_lit("seq_4", 32'h4, 1'b1);
      cyc(); check_lit("seq_8", 32'h8, 1'b1);
      cyc(); check_lit("seq_c", 32'hC, 1'b1);
      cyc(); check_lit("seq_10", 32'h10, 1'b1);

      // Redirect pulse.
      drive(1'b1, 32'h12580, 1'b0);
      cyc(); check_lit("redir", 32'h12580, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      cyc(); check_lit("redir_seq1", 32'h12584, 1'b1);
      cyc(); cyc(); cyc(); check_lit("redir_seq4", 32'h12590, 1'b1);

      // Halt while sequencing.
      drive(1'b0, 32'h0, 1'b1);
      cyc(); check_lit("halt_1", 32'h12594, 1'b0);
      cyc(); cyc(); check_lit("halt_hold", 32'h12594, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      cyc(); check_lit("halt_release", 32'h12594, 1'b1);
      cyc(); check_lit("halt_after", 32'h12598, 1'b1);

      // Redirect while halted.
      drive(1'b0, 32'h0, 1'b1);
      cyc(); check_lit("halt2", 32'h1259C, 1'b0);
      drive(1'b1, 32'h400, 1'b1);
      cyc(); check_lit("redir_halted", 32'h400, 1'b0);
      drive(1'b0, 32'h0, 1'b1);
      cyc(); check_lit("redir_halted_hold", 32'h400, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      cyc(); check_lit("redir_halted_rel", 32'h400, 1'b1);
      cyc(); check_lit("redir_halted_seq", 32'h404, 1'b1);

      // Wrap-around.
      drive(1'b1, 32'hFFFF_FFF8, 1'b0);
      cyc(); check_lit("wrap_f8", 32'hFFFF_FFF8, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      cyc(); check_lit("wrap_fc", 32'hFFFF_FFFC, 1'b1);
      cyc(); check_lit("wrap_0", 32'h0, 1'b1);
      cyc(); check_lit("wrap_4", 32'h4, 1'b1);

      // Async reset mid-run, with a pending redirect and halt discarded.
      drive(1'b1, 32'hABCD_0000, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_lit("async_rst", 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      cyc(); check_lit("async_rst_hold", 32'h0, 1'b0);
      #2 rst_n = 1'b1;
      cyc(); check_lit("restart_0", 32'h0, 1'b1);
      cyc(); check_lit("restart_4", 32'h4, 1'b1);

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         logic              cp;
         logic              h;
         logic [ADDR_W-1:0] np;
         cp = ($urandom_range(0, 99) < 15);
         h  = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 3) == 0)
            np = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            np = $urandom;
         drive(cp, np, h);
         if ($urandom_range(0, 199) == 0)
            async_reset("rand_async_rst");
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
